// File: rtl/character_jump_if.sv
// Bus between the game state machine (master) and the character responder (slave).
interface character_jump_if #(
    parameter int unsigned COLS = 8
) ();
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic            frame_tick;
    logic            enable;
    logic            jump_left;
    logic            jump_right;
    logic [COLS-1:0] block_mask;
    logic            restart;
    logic [CW-1:0]   start_col;
    logic [11:0]     xpos;
    logic [11:0]     ypos;
    logic [CW-1:0]   col;
    logic            busy;
    logic            character_landed;
    logic            jump_fail;

    modport master (
        output frame_tick, enable, jump_left, jump_right, block_mask, restart, start_col,
        input  xpos, ypos, col, busy, character_landed, jump_fail
    );

    modport slave (
        input  frame_tick, enable, jump_left, jump_right, block_mask, restart, start_col,
        output xpos, ypos, col, busy, character_landed, jump_fail
    );
endinterface

// File: rtl/character_jump.sv
// Character hop animator: accepts one-column jump requests, animates the arc on frame ticks,
// checks the landing column against the block map and reports landed/fail pulses.
module character_jump #(
    parameter int unsigned COLS        = 8,
    parameter int unsigned COL_W       = 80,
    parameter int unsigned Y_BASE      = 400,
    parameter int unsigned JUMP_H      = 64,
    parameter int unsigned JUMP_FRAMES = 16,
    parameter int unsigned FALL_FRAMES = 32,
    parameter int unsigned FALL_STEP   = 8
) (
    input logic                clk,
    input logic                rst,
    character_jump_if.slave    bus_io
);
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned FMAX = (JUMP_FRAMES > FALL_FRAMES) ? JUMP_FRAMES : FALL_FRAMES;
    localparam int unsigned FW   = $clog2(FMAX + 1);

    localparam logic [11:0]   XSTEP    = 12'(COL_W / JUMP_FRAMES);
    localparam logic [11:0]   HSTEP    = 12'((2 * JUMP_H) / JUMP_FRAMES);
    localparam logic [11:0]   YBASE    = 12'(Y_BASE);
    localparam logic [11:0]   FSTEP    = 12'(FALL_STEP);
    localparam logic [FW-1:0] JF_CNT   = FW'(JUMP_FRAMES);
    localparam logic [FW-1:0] JF_HALF  = FW'(JUMP_FRAMES / 2);
    localparam logic [FW-1:0] FF_CNT   = FW'(FALL_FRAMES);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {StIdle, StJump, StFall, StDead} state_e;

    state_e        state_q;
    logic [CW-1:0] col_q, target_q;
    logic          dir_q;       // 1 = right
    logic          in_range_q;
    logic [FW-1:0] fcnt_q;
    logic [11:0]   xpos_q, ypos_q;
    logic          busy_q, landed_q, fail_q;

    logic          req_valid;
    logic          req_right;
    logic [CW-1:0] req_target;
    logic          req_in_range;
    logic [FW-1:0] fcnt_inc;
    logic [11:0]   land_x, start_x;
    logic          landing_ok;

    // Decode the incoming request and precompute landing/restart geometry.
    always_comb begin
        req_valid    = bus_io.enable && (bus_io.jump_left ^ bus_io.jump_right);
        req_right    = bus_io.jump_right;
        // Edge columns wrap here, but in_range masks that target off.
        req_target   = req_right ? col_q + CW'(1) : col_q - CW'(1);
        req_in_range = req_right ? (col_q < LAST_COL) : (col_q != '0);
        fcnt_inc     = fcnt_q + FW'(1);
        land_x       = 12'(32'(target_q) * COL_W);
        start_x      = 12'(32'(bus_io.start_col) * COL_W);
        landing_ok   = in_range_q && bus_io.block_mask[target_q];
    end

    // Hop state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            col_q      <= '0;
            target_q   <= '0;
            dir_q      <= 1'b0;
            in_range_q <= 1'b0;
            fcnt_q     <= '0;
            xpos_q     <= '0;
            ypos_q     <= YBASE;
            busy_q     <= 1'b0;
            landed_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            landed_q <= 1'b0;
            fail_q   <= 1'b0;
            if (bus_io.restart) begin
                state_q <= StIdle;
                col_q   <= bus_io.start_col;
                xpos_q  <= start_x;
                ypos_q  <= YBASE;
                fcnt_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (req_valid) begin
                            dir_q      <= req_right;
                            target_q   <= req_target;
                            in_range_q <= req_in_range;
                            fcnt_q     <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= StJump;
                        end
                    end
                    StJump: begin
                        if (bus_io.frame_tick) begin
                            if (fcnt_inc == JF_CNT) begin
                                // Snap to the exact landing spot to absorb any rounding.
                                ypos_q <= YBASE;
                                fcnt_q <= '0;
                                if (in_range_q) xpos_q <= land_x;
                                if (landing_ok) begin
                                    col_q    <= target_q;
                                    landed_q <= 1'b1;
                                    busy_q   <= 1'b0;
                                    state_q  <= StIdle;
                                end else begin
                                    state_q <= StFall;
                                end
                            end else begin
                                fcnt_q <= fcnt_inc;
                                ypos_q <= (fcnt_inc <= JF_HALF) ? ypos_q - HSTEP
                                                                : ypos_q + HSTEP;
                                if (in_range_q) begin
                                    xpos_q <= dir_q ? xpos_q + XSTEP : xpos_q - XSTEP;
                                end
                            end
                        end
                    end
                    StFall: begin
                        if (bus_io.frame_tick) begin
                            ypos_q <= ypos_q + FSTEP;
                            fcnt_q <= fcnt_inc;
                            if (fcnt_inc == FF_CNT) begin
                                fail_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= StDead;
                            end
                        end
                    end
                    StDead: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Drive the bus from the registered state.
    always_comb begin
        bus_io.xpos             = xpos_q;
        bus_io.ypos             = ypos_q;
        bus_io.col              = col_q;
        bus_io.busy             = busy_q;
        bus_io.character_landed = landed_q;
        bus_io.jump_fail        = fail_q;
    end
endmodule

// File: tb/tb_character_jump.sv
// Bench for character_jump: vector table, directed hop sequences and a random run
// checked against a closed-form model of the hop trajectory.
module tb_character_jump;
    localparam int COLS = 8, COL_W = 80, Y_BASE = 400, JF = 16, FF = 32;
    localparam int XSTEP = 5, HSTEP = 8, FALL_STEP = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    character_jump_if #(.COLS(COLS)) bus ();

    character_jump dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: phase 0 standing, 1 hopping, 2 falling, 3 dead.
    int m_phase, m_col, m_dir, m_tgt, m_n;
    bit m_land, m_fail;

    function automatic bit tgt_ok();
        return (m_tgt >= 0) && (m_tgt < COLS);
    endfunction

    function automatic int exp_x();
        case (m_phase)
            0:       return m_col * COL_W;
            1:       return m_col * COL_W + (tgt_ok() ? m_dir * XSTEP * m_n : 0);
            default: return (tgt_ok() ? m_tgt : m_col) * COL_W;
        endcase
    endfunction

    function automatic int exp_y();
        int up, down;
        up   = (m_n < JF / 2) ? m_n : JF / 2;
        down = (m_n > JF / 2) ? m_n - JF / 2 : 0;
        case (m_phase)
            0:       return Y_BASE;
            1:       return Y_BASE - HSTEP * up + HSTEP * down;
            default: return Y_BASE + FALL_STEP * m_n;
        endcase
    endfunction

    task automatic model_update(input logic r, rs, input logic [2:0] sc,
                                input logic en, jl, jr, tk, input logic [7:0] mk);
        m_land = 0;
        m_fail = 0;
        if (r) begin
            m_phase = 0; m_col = 0; m_n = 0;
        end else if (rs) begin
            m_phase = 0; m_col = int'(sc); m_n = 0;
        end else begin
            case (m_phase)
                0: if (en && (jl != jr)) begin
                    m_dir = jr ? 1 : -1;
                    m_tgt = m_col + m_dir;
                    m_n = 0;
                    m_phase = 1;
                end
                1: if (tk) begin
                    m_n++;
                    if (m_n == JF) begin
                        if (tgt_ok() && mk[m_tgt]) begin
                            m_col = m_tgt; m_phase = 0; m_n = 0; m_land = 1;
                        end else begin
                            m_phase = 2; m_n = 0;
                        end
                    end
                end
                2: if (tk) begin
                    m_n++;
                    if (m_n == FF) begin
                        m_phase = 3; m_fail = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample just after the edge.
    task automatic step(input logic r, rs, input logic [2:0] sc,
                        input logic en, jl, jr, tk, input logic [7:0] mk);
        rst               = r;
        bus.restart       = rs;
        bus.start_col     = sc;
        bus.enable        = en;
        bus.jump_left     = jl;
        bus.jump_right    = jr;
        bus.frame_tick    = tk;
        bus.block_mask    = mk;
        model_update(r, rs, sc, en, jl, jr, tk, mk);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [7:0] mk);
        step(0, 0, 3'd0, 1, 0, 0, 1, mk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".x"}, 32'(bus.xpos), 32'(exp_x()));
        chk({tag, ".y"}, 32'(bus.ypos), 32'(exp_y()));
        chk({tag, ".col"}, 32'(bus.col), 32'(m_col));
        chk({tag, ".busy"}, 32'(bus.busy), 32'((m_phase == 1) || (m_phase == 2)));
        chk({tag, ".landed"}, 32'(bus.character_landed), 32'(m_land));
        chk({tag, ".fail"}, 32'(bus.jump_fail), 32'(m_fail));
    endtask

    typedef struct {
        logic r, rs; logic [2:0] sc; logic en, jl, jr, tk; logic [7:0] mk;
        int ex, ey, ecol; logic ebusy, eland, efail;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{1, 0, 3'd0, 0, 0, 0, 0, 8'hFF,   0, 400, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 3'd2, 0, 0, 0, 0, 8'hFF, 160, 400, 2, 0, 0, 0};
        vt[2]  = '{0, 0, 3'd0, 1, 1, 1, 0, 8'hFF, 160, 400, 2, 0, 0, 0};
        vt[3]  = '{0, 0, 3'd0, 0, 0, 1, 0, 8'hFF, 160, 400, 2, 0, 0, 0};
        vt[4]  = '{0, 0, 3'd0, 1, 0, 0, 1, 8'hFF, 160, 400, 2, 0, 0, 0};
        vt[5]  = '{0, 1, 3'd7, 0, 0, 0, 0, 8'hFF, 560, 400, 7, 0, 0, 0};
        vt[6]  = '{0, 1, 3'd2, 1, 0, 1, 0, 8'hFF, 160, 400, 2, 0, 0, 0};
        vt[7]  = '{0, 0, 3'd0, 1, 0, 1, 1, 8'hFF, 160, 400, 2, 1, 0, 0};
        vt[8]  = '{0, 0, 3'd0, 1, 0, 0, 1, 8'hFF, 165, 392, 2, 1, 0, 0};
        vt[9]  = '{0, 0, 3'd0, 1, 1, 0, 0, 8'hFF, 165, 392, 2, 1, 0, 0};
        vt[10] = '{0, 0, 3'd0, 1, 0, 1, 1, 8'hFF, 170, 384, 2, 1, 0, 0};
        vt[11] = '{1, 0, 3'd0, 1, 0, 0, 0, 8'hFF,   0, 400, 0, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            step(vt[i].r, vt[i].rs, vt[i].sc, vt[i].en, vt[i].jl, vt[i].jr, vt[i].tk,
                 vt[i].mk);
            chk($sformatf("vec%0d.x", i), 32'(bus.xpos), 32'(vt[i].ex));
            chk($sformatf("vec%0d.y", i), 32'(bus.ypos), 32'(vt[i].ey));
            chk($sformatf("vec%0d.col", i), 32'(bus.col), 32'(vt[i].ecol));
            chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vt[i].ebusy));
            chk($sformatf("vec%0d.landed", i), 32'(bus.character_landed), 32'(vt[i].eland));
            chk($sformatf("vec%0d.fail", i), 32'(bus.jump_fail), 32'(vt[i].efail));
        end

        // Successful hop right from column 2.
        step(0, 1, 3'd2, 1, 0, 0, 0, 8'hFF);
        step(0, 0, 3'd0, 1, 0, 1, 0, 8'hFF);
        for (int t = 1; t <= 8; t++) tick(8'hFF);
        chk("hop.apex_x", 32'(bus.xpos), 200);
        chk("hop.apex_y", 32'(bus.ypos), 336);
        for (int t = 9; t <= 16; t++) tick(8'hFF);
        chk("hop.land_x", 32'(bus.xpos), 240);
        chk("hop.land_y", 32'(bus.ypos), 400);
        chk("hop.col", 32'(bus.col), 3);
        chk("hop.landed", 32'(bus.character_landed), 1);
        chk("hop.busy", 32'(bus.busy), 0);
        step(0, 0, 3'd0, 1, 0, 0, 0, 8'hFF);
        chk("hop.landed_once", 32'(bus.character_landed), 0);

        // Hop onto a missing block, fall, die, ignore requests, restart.
        step(0, 1, 3'd2, 1, 0, 0, 0, 8'hF7);
        step(0, 0, 3'd0, 1, 0, 1, 0, 8'hF7);
        for (int t = 1; t <= 16; t++) tick(8'hF7);
        chk("miss.busy", 32'(bus.busy), 1);
        chk("miss.col", 32'(bus.col), 2);
        chk("miss.landed", 32'(bus.character_landed), 0);
        for (int t = 1; t <= 32; t++) tick(8'hF7);
        chk("miss.fall_y", 32'(bus.ypos), 656);
        chk("miss.fail", 32'(bus.jump_fail), 1);
        chk("miss.busy_dead", 32'(bus.busy), 0);
        step(0, 0, 3'd0, 1, 1, 0, 1, 8'hF7);
        step(0, 0, 3'd0, 1, 0, 0, 0, 8'hF7);
        chk("dead.fail_once", 32'(bus.jump_fail), 0);
        chk("dead.busy", 32'(bus.busy), 0);
        chk("dead.y_hold", 32'(bus.ypos), 656);
        chk("dead.x_hold", 32'(bus.xpos), 240);
        step(0, 1, 3'd2, 1, 0, 0, 0, 8'hFF);
        chk("revive.y", 32'(bus.ypos), 400);
        chk("revive.x", 32'(bus.xpos), 160);

        // Left off the edge from column 0.
        step(0, 1, 3'd0, 1, 0, 0, 0, 8'hFF);
        step(0, 0, 3'd0, 1, 1, 0, 0, 8'hFF);
        for (int t = 1; t <= 8; t++) tick(8'hFF);
        chk("edge.apex_x", 32'(bus.xpos), 0);
        chk("edge.apex_y", 32'(bus.ypos), 336);
        for (int t = 9; t <= 47; t++) tick(8'hFF);
        chk("edge.no_fail_yet", 32'(bus.jump_fail), 0);
        tick(8'hFF);
        chk("edge.fail", 32'(bus.jump_fail), 1);
        chk("edge.x", 32'(bus.xpos), 0);

        // Reset mid-hop.
        step(0, 1, 3'd4, 1, 0, 0, 0, 8'hFF);
        step(0, 0, 3'd0, 1, 0, 1, 0, 8'hFF);
        for (int t = 1; t <= 5; t++) tick(8'hFF);
        chk("rsthop.x_mid", 32'(bus.xpos), 345);
        chk("rsthop.y_mid", 32'(bus.ypos), 360);
        step(1, 0, 3'd0, 1, 0, 0, 1, 8'hFF);
        check_model("rsthop");
        chk("rsthop.x", 32'(bus.xpos), 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic r, rs, en, jl, jr, tk;
            logic [2:0] sc;
            logic [7:0] mk;
            r  = ($urandom_range(299) == 0);
            rs = ($urandom_range(119) == 0);
            sc = 3'($urandom_range(7));
            en = ($urandom_range(7) != 0);
            jl = ($urandom_range(3) == 0);
            jr = ($urandom_range(3) == 0);
            tk = ($urandom_range(1) == 0);
            mk = 8'($urandom | $urandom);
            step(r, rs, sc, en, jl, jr, tk, mk);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
